// File: rtl/back_propper.sv
// rtl/back_propper.sv - weight update and upstream error for one learning neuron
//
// Purpose: from the 32 dendrite inputs, 33 current weights (index 32 = bias),
// the error term and the learning rate M/D, computes the updated weights and
// the error passed back to each upstream neuron, one registered evaluation per
// enabled edge.
//
// Ports:
//   bp_clock          in   clock, rising edge
//   bp_reset          in   synchronous active-high reset, clears all outputs
//   bp_update_en      in   load new results at the next edge
//   bp_dendrites      in   32 x signed 32-bit inputs x[i]
//   bp_weights        in   33 x signed 32-bit weights w[i]
//   bp_backprop       in   signed 64-bit error term
//   bp_trainingMul    in   unsigned 32-bit learning-rate numerator M
//   bp_trainingDiv    in   unsigned 32-bit learning-rate denominator D
//   bp_backpropChange out  32 x signed 32-bit upstream error c[i]
//   bp_weightsNew     out  33 x signed 32-bit updated weights n[i]
//
// Configuration macro: BP_SATURATE_EN - when defined, every final result
// saturates to the signed 32-bit range; otherwise it wraps to the low 32 bits.

module back_propper (
  input  logic               bp_clock,
  input  logic               bp_reset,
  input  logic               bp_update_en,
  input  logic signed [31:0] bp_dendrites      [0:31],
  input  logic signed [31:0] bp_weights        [0:32],
  input  logic signed [63:0] bp_backprop,
  input  logic        [31:0] bp_trainingMul,
  input  logic        [31:0] bp_trainingDiv,
  output logic signed [31:0] bp_backpropChange [0:31],
  output logic signed [31:0] bp_weightsNew     [0:32]
);

  // 64 + 32 + 33 bits is enough for delta*x*M; 160 leaves margin for every product.
  localparam int W = 160;

  function automatic logic signed [31:0] narrow(input logic signed [W-1:0] v);
`ifdef BP_SATURATE_EN
    logic signed [W-1:0] max_v;
    logic signed [W-1:0] min_v;
    max_v = {{(W-32){1'b0}}, 32'h7FFF_FFFF};
    min_v = {{(W-32){1'b1}}, 32'h8000_0000};
    if (v > max_v)      return 32'sh7FFF_FFFF;
    else if (v < min_v) return 32'sh8000_0000;
    else                return v[31:0];
`else
    return v[31:0];
`endif
  endfunction

  logic signed [W-1:0] delta_ext;
  logic signed [W-1:0] mul_ext;
  logic signed [W-1:0] div_ext;
  logic signed [31:0]  n_next [0:32];
  logic signed [31:0]  c_next [0:31];

  // Sign-extend the error term; M and D are unsigned so they zero-extend.
  assign delta_ext = {{(W-64){bp_backprop[63]}}, bp_backprop};
  assign mul_ext   = {{(W-32){1'b0}}, bp_trainingMul};
  assign div_ext   = {{(W-32){1'b0}}, bp_trainingDiv};

  always_comb begin
    logic signed [W-1:0] x_ext;
    logic signed [W-1:0] w_ext;
    logic signed [W-1:0] step;
    for (int i = 0; i < 33; i++) begin
      w_ext = {{(W-32){bp_weights[i][31]}}, bp_weights[i]};
      // The bias lane has an implicit input of 1.
      if (i < 32) x_ext = {{(W-32){bp_dendrites[i][31]}}, bp_dendrites[i]};
      else        x_ext = {{(W-1){1'b0}}, 1'b1};
      // Signed division truncates toward zero; D = 0 means no weight change.
      if (bp_trainingDiv == 32'd0) step = '0;
      else                         step = (delta_ext * x_ext * mul_ext) / div_ext;
      n_next[i] = narrow(w_ext - step);
    end
    for (int i = 0; i < 32; i++) begin
      w_ext     = {{(W-32){bp_weights[i][31]}}, bp_weights[i]};
      c_next[i] = narrow(delta_ext * w_ext);
    end
  end

  always_ff @(posedge bp_clock) begin
    if (bp_reset) begin
      for (int i = 0; i < 33; i++) bp_weightsNew[i] <= '0;
      for (int i = 0; i < 32; i++) bp_backpropChange[i] <= '0;
    end else if (bp_update_en) begin
      for (int i = 0; i < 33; i++) bp_weightsNew[i] <= n_next[i];
      for (int i = 0; i < 32; i++) bp_backpropChange[i] <= c_next[i];
    end
  end

endmodule

// File: tb/tb_back_propper.sv
// tb/tb_back_propper.sv - directed self-checking bench for back_propper

module tb_back_propper;

  logic               bp_clock = 1'b0;
  logic               bp_reset;
  logic               bp_update_en;
  logic signed [31:0] bp_dendrites      [0:31];
  logic signed [31:0] bp_weights        [0:32];
  logic signed [63:0] bp_backprop;
  logic        [31:0] bp_trainingMul;
  logic        [31:0] bp_trainingDiv;
  logic signed [31:0] bp_backpropChange [0:31];
  logic signed [31:0] bp_weightsNew     [0:32];

  int errors = 0;
  int checks = 0;

  back_propper dut (
    .bp_clock          (bp_clock),
    .bp_reset          (bp_reset),
    .bp_update_en      (bp_update_en),
    .bp_dendrites      (bp_dendrites),
    .bp_weights        (bp_weights),
    .bp_backprop       (bp_backprop),
    .bp_trainingMul    (bp_trainingMul),
    .bp_trainingDiv    (bp_trainingDiv),
    .bp_backpropChange (bp_backpropChange),
    .bp_weightsNew     (bp_weightsNew)
  );

  always #5 bp_clock = ~bp_clock;

  task automatic tick();
    @(posedge bp_clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 32; i++) bp_dendrites[i] = '0;
    for (int i = 0; i < 33; i++) bp_weights[i] = '0;
    bp_backprop    = '0;
    bp_trainingMul = '0;
    bp_trainingDiv = '0;
  endtask

  logic [31:0] held_n0;
  logic [31:0] held_c0;

  initial begin
    // Reset with every input nonzero and enable high.
    bp_reset = 1'b1;
    bp_update_en = 1'b1;
    for (int i = 0; i < 32; i++) bp_dendrites[i] = 32'sd3 + i;
    for (int i = 0; i < 33; i++) bp_weights[i] = 32'sd100 - i;
    bp_backprop    = 64'sd7;
    bp_trainingMul = 32'd2;
    bp_trainingDiv = 32'd1;
    tick();
    for (int i = 0; i < 33; i++) chk($sformatf("reset_n%0d", i), bp_weightsNew[i], 32'h0);
    for (int i = 0; i < 32; i++) chk($sformatf("reset_c%0d", i), bp_backpropChange[i], 32'h0);

    // Basic update.
    bp_reset = 1'b0;
    clear_inputs();
    bp_backprop = 64'sd2; bp_dendrites[0] = 32'sd3;
    bp_weights[0] = 32'sd10; bp_weights[32] = 32'sd5;
    bp_trainingMul = 32'd1; bp_trainingDiv = 32'd1;
    tick();
    chk("basic_n0", bp_weightsNew[0], 32'd4);
    chk("basic_n32", bp_weightsNew[32], 32'd3);
    chk("basic_c0", bp_backpropChange[0], 32'd20);
    for (int i = 1; i < 32; i++) begin
      chk($sformatf("basic_n%0d", i), bp_weightsNew[i], 32'h0);
      chk($sformatf("basic_c%0d", i), bp_backpropChange[i], 32'h0);
    end

    // Truncation toward zero.
    clear_inputs();
    bp_weights[0] = 32'sd7; bp_dendrites[0] = 32'sd1;
    bp_trainingMul = 32'd1; bp_trainingDiv = 32'd2;
    bp_backprop = 64'sd1;
    tick();
    chk("trunc_pos_n0", bp_weightsNew[0], 32'd7);
    bp_backprop = -64'sd3;
    tick();
    chk("trunc_neg_n0", bp_weightsNew[0], 32'd8);
    chk("trunc_neg_c0", bp_backpropChange[0], -32'sd21);

    // Divide by zero: weights unchanged, upstream error still computed.
    clear_inputs();
    bp_trainingDiv = 32'd0; bp_trainingMul = 32'd1;
    bp_backprop = 64'sd5; bp_weights[3] = -32'sd9; bp_dendrites[3] = 32'sd4;
    bp_weights[32] = 32'sd11;
    tick();
    chk("div0_n3", bp_weightsNew[3], -32'sd9);
    chk("div0_c3", bp_backpropChange[3], -32'sd45);
    chk("div0_n32", bp_weightsNew[32], 32'd11);

    // Wide intermediate: 2^40 * 4 * 8 / 2^31 = 16384; c0 = 2^40 * 20000.
    clear_inputs();
    bp_backprop = 64'sd1 <<< 40; bp_dendrites[0] = 32'sd4;
    bp_trainingMul = 32'd8; bp_trainingDiv = 32'h8000_0000;
    bp_weights[0] = 32'sd20000;
    tick();
    chk("wide_n0", bp_weightsNew[0], 32'd3616);
`ifdef BP_SATURATE_EN
    chk("wide_c0", bp_backpropChange[0], 32'h7FFF_FFFF);
`else
    chk("wide_c0", bp_backpropChange[0], 32'h0);
`endif

    // Overflow of the final narrowing.
    clear_inputs();
    bp_weights[0] = 32'sh7FFF_FFF0; bp_backprop = -64'sd1;
    bp_dendrites[0] = 32'sh100; bp_trainingMul = 32'd1; bp_trainingDiv = 32'd1;
    tick();
`ifdef BP_SATURATE_EN
    chk("ovf_n0", bp_weightsNew[0], 32'h7FFF_FFFF);
    held_n0 = 32'h7FFF_FFFF;
`else
    chk("ovf_n0", bp_weightsNew[0], 32'h8000_00F0);
    held_n0 = 32'h8000_00F0;
`endif
    chk("ovf_c0", bp_backpropChange[0], 32'h8000_0010);
    held_c0 = 32'h8000_0010;

    // Hold for 5 cycles while inputs change.
    bp_update_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bp_weights[0] = 32'sd50 + k; bp_dendrites[0] = 32'sd1;
      bp_backprop = 64'sd1; bp_trainingDiv = 32'd1;
      tick();
      chk($sformatf("hold%0d_n0", k), bp_weightsNew[0], held_n0);
      chk($sformatf("hold%0d_c0", k), bp_backpropChange[0], held_c0);
    end
    // w0 = 54, delta = 1, x0 = 1, M = 1, D = 1 -> n0 = 53, c0 = 54.
    bp_update_en = 1'b1;
    tick();
    chk("resume_n0", bp_weightsNew[0], 32'd53);
    chk("resume_c0", bp_backpropChange[0], 32'd54);

    // Reset mid-stream discards the pending update and outputs stay 0.
    bp_reset = 1'b1;
    tick();
    chk("midrst_n0", bp_weightsNew[0], 32'h0);
    bp_reset = 1'b0;
    bp_update_en = 1'b0;
    tick();
    chk("midrst_hold_n0", bp_weightsNew[0], 32'h0);
    chk("midrst_hold_c0", bp_backpropChange[0], 32'h0);
    bp_update_en = 1'b1;
    tick();
    chk("post_rst_n0", bp_weightsNew[0], 32'd53);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
